// File: rtl/q_pulse_counter.sv
// Pulse-train receiver: synchronizes q_serialized, counts rising edges
// and returns count and charge (count * Q_PER_PULSE) over valid/ready.
module q_pulse_counter #(
  parameter int BUS_WIDTH   = 10,
  parameter int Q_PER_PULSE = 30,
  parameter int SYNC_STAGES = 2,
  parameter int GAP_CYCLES  = 16,
  parameter int ARM_TIMEOUT = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 q_serialized,
  input  logic                 out_ready,
  output logic                 busy,
  output logic                 out_valid,
  output logic [BUS_WIDTH-1:0] n_pulses,
  output logic [BUS_WIDTH-1:0] q_measured,
  output logic                 overflow,
  output logic                 timeout
);

  localparam int AW = (ARM_TIMEOUT > 1) ? $clog2(ARM_TIMEOUT) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int PW = 2 * BUS_WIDTH;

  localparam logic [BUS_WIDTH-1:0] LP_MAX      = '1;
  localparam logic [AW-1:0]        LP_ARM_LAST = AW'(ARM_TIMEOUT - 1);
  localparam logic [GW-1:0]        LP_GAP_LAST = GW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_COUNT,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_nx;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_sync_prev;
  logic                   w_rise;

  logic [BUS_WIDTH-1:0] r_count;
  logic [BUS_WIDTH-1:0] w_count_nx;
  logic                 r_sat;
  logic                 w_sat_nx;
  logic [AW-1:0]        r_arm;
  logic [AW-1:0]        w_arm_nx;
  logic [GW-1:0]        r_gap;
  logic [GW-1:0]        w_gap_nx;

  logic                 r_valid;
  logic                 w_valid_nx;
  logic [BUS_WIDTH-1:0] r_n;
  logic [BUS_WIDTH-1:0] w_n_nx;
  logic [BUS_WIDTH-1:0] r_q;
  logic [BUS_WIDTH-1:0] w_q_nx;
  logic                 r_ovf;
  logic                 w_ovf_nx;
  logic                 r_to;
  logic                 w_to_nx;

  logic [PW-1:0]        w_prod;
  logic                 w_prod_ovf;

  // Sync chain keeps running in every state so a level already high
  // when arming never looks like a fresh edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync      <= '0;
      r_sync_prev <= 1'b0;
    end else begin
      r_sync      <= {r_sync[SYNC_STAGES-2:0], q_serialized};
      r_sync_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign w_rise = r_sync[SYNC_STAGES-1] & ~r_sync_prev;

  assign w_prod     = PW'(r_count) * PW'(Q_PER_PULSE);
  assign w_prod_ovf = |w_prod[PW-1:BUS_WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_sat   <= 1'b0;
      r_arm   <= '0;
      r_gap   <= '0;
      r_valid <= 1'b0;
      r_n     <= '0;
      r_q     <= '0;
      r_ovf   <= 1'b0;
      r_to    <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_count <= w_count_nx;
      r_sat   <= w_sat_nx;
      r_arm   <= w_arm_nx;
      r_gap   <= w_gap_nx;
      r_valid <= w_valid_nx;
      r_n     <= w_n_nx;
      r_q     <= w_q_nx;
      r_ovf   <= w_ovf_nx;
      r_to    <= w_to_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_count_nx = r_count;
    w_sat_nx   = r_sat;
    w_arm_nx   = r_arm;
    w_gap_nx   = r_gap;
    w_valid_nx = r_valid;
    w_n_nx     = r_n;
    w_q_nx     = r_q;
    w_ovf_nx   = r_ovf;
    w_to_nx    = r_to;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nx = S_ARMED;
          w_count_nx = '0;
          w_sat_nx   = 1'b0;
          w_arm_nx   = '0;
          w_gap_nx   = '0;
        end
      end
      S_ARMED: begin
        if (w_rise) begin
          w_state_nx = S_COUNT;
          w_count_nx = BUS_WIDTH'(1);
          w_gap_nx   = '0;
        end else if (r_arm == LP_ARM_LAST) begin
          w_state_nx = S_DONE;
          w_count_nx = '0;
          w_valid_nx = 1'b1;
          w_n_nx     = '0;
          w_q_nx     = '0;
          w_ovf_nx   = 1'b0;
          w_to_nx    = 1'b1;
        end else begin
          w_arm_nx = r_arm + AW'(1);
        end
      end
      S_COUNT: begin
        if (w_rise) begin
          w_gap_nx = '0;
          if (r_count == LP_MAX) begin
            w_sat_nx = 1'b1;
          end else begin
            w_count_nx = r_count + BUS_WIDTH'(1);
          end
        end else if (r_gap == LP_GAP_LAST) begin
          w_state_nx = S_DONE;
          w_valid_nx = 1'b1;
          w_n_nx     = r_count;
          w_q_nx     = w_prod_ovf ? LP_MAX : w_prod[BUS_WIDTH-1:0];
          w_ovf_nx   = r_sat | w_prod_ovf;
          w_to_nx    = 1'b0;
        end else begin
          w_gap_nx = r_gap + GW'(1);
        end
      end
      S_DONE: begin
        if (out_ready) begin
          w_state_nx = S_IDLE;
          w_valid_nx = 1'b0;
          w_n_nx     = '0;
          w_q_nx     = '0;
          w_ovf_nx   = 1'b0;
          w_to_nx    = 1'b0;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  assign busy       = (r_state == S_ARMED) | (r_state == S_COUNT);
  assign out_valid  = r_valid;
  assign n_pulses   = r_n;
  assign q_measured = r_q;
  assign overflow   = r_ovf;
  assign timeout    = r_to;

endmodule

// File: tb/tb_q_pulse_counter.sv
// Scoreboard bench for q_pulse_counter: asynchronous jittered pulse
// trains, expected results from a count/charge model, popped on output.
module tb_q_pulse_counter;

  localparam int BW   = 10;
  localparam int QP   = 30;
  localparam int SS   = 2;
  localparam int GAP  = 16;
  localparam int ARMT = 1024;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          q_ser;
  logic          out_ready;
  logic          busy;
  logic          out_valid;
  logic [BW-1:0] n_pulses;
  logic [BW-1:0] q_measured;
  logic          overflow;
  logic          timeout;

  typedef struct {
    int n;
    int q;
    int ovf;
    int to;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_pass = 0;
  bit   hold_ready = 1'b0;
  bit   ready_val = 1'b0;

  bit            m_seen = 1'b0;
  bit            m_drop = 1'b0;
  exp_t          m_e;
  logic [BW-1:0] m_n;
  logic [BW-1:0] m_q;
  logic          m_o;
  logic          m_t;

  always #5 clk = ~clk;

  q_pulse_counter #(
    .BUS_WIDTH  (BW),
    .Q_PER_PULSE(QP),
    .SYNC_STAGES(SS),
    .GAP_CYCLES (GAP),
    .ARM_TIMEOUT(ARMT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .q_serialized(q_ser),
    .out_ready   (out_ready),
    .busy        (busy),
    .out_valid   (out_valid),
    .n_pulses    (n_pulses),
    .q_measured  (q_measured),
    .overflow    (overflow),
    .timeout     (timeout)
  );

  task automatic chk(input string name, input longint act,
                     input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Expected result straight from the counting rules.
  function automatic exp_t model(input int n);
    exp_t e;
    int cnt;
    int prod;
    int lim;
    lim   = (1 << BW) - 1;
    cnt   = (n > lim) ? lim : n;
    prod  = cnt * QP;
    e.n   = cnt;
    e.q   = (prod > lim) ? lim : prod;
    e.ovf = ((n > lim) || (prod > lim)) ? 1 : 0;
    e.to  = (n == 0) ? 1 : 0;
    return e;
  endfunction

  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      out_ready = hold_ready ? ready_val : 1'($urandom_range(0, 1));
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (out_valid) begin
        if (!m_seen) begin
          m_seen = 1'b1;
          m_n = n_pulses;
          m_q = q_measured;
          m_o = overflow;
          m_t = timeout;
          chk("sb_has_entry", longint'(sb.size() > 0), 1);
          if (sb.size() > 0) begin
            m_e = sb.pop_front();
            chk("n_pulses", n_pulses, m_e.n);
            chk("q_measured", q_measured, m_e.q);
            chk("overflow", overflow, m_e.ovf);
            chk("timeout", timeout, m_e.to);
          end
        end else begin
          chk("stable", {n_pulses, q_measured, overflow, timeout},
              {m_n, m_q, m_o, m_t});
        end
        if (out_ready) begin
          m_seen = 1'b0;
          m_drop = 1'b1;
        end
      end else if (m_drop) begin
        m_drop = 1'b0;
        chk("after_accept",
            {busy, n_pulses, q_measured, overflow, timeout}, 0);
      end
    end
  end

  task automatic arm();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic train(input int n);
    for (int i = 0; i < n; i++) begin
      q_ser = 1'b1;
      #($urandom_range(17, 63));
      q_ser = 1'b0;
      #($urandom_range(17, 63));
    end
  endtask

  task automatic clean_pulse();
    @(negedge clk);
    q_ser = 1'b1;
    repeat (4) @(negedge clk);
    q_ser = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_idle(input int lim);
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !out_valid && !busy) break;
    end
    chk("drain_sb", sb.size(), 0);
    chk("drain_valid", out_valid, 0);
  endtask

  task automatic run_txn(input int n);
    sb.push_back(model(n));
    arm();
    train(n);
    wait_idle(300);
  endtask

  task automatic chk_zero(input string name);
    chk(name, {out_valid, busy, n_pulses, q_measured, overflow, timeout}, 0);
  endtask

  initial begin
    int cnt;
    rst   = 1'b1;
    start = 1'b0;
    q_ser = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("reset_state");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    sb.push_back(model(3));
    arm();
    clean_pulse();
    clean_pulse();
    @(negedge clk);
    q_ser = 1'b1;
    cnt = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      cnt++;
      @(negedge clk);
      if (cnt == 4) q_ser = 1'b0;
      if (out_valid) break;
    end
    q_ser = 1'b0;
    chk("gap_latency", cnt, SS + 1 + GAP);
    wait_idle(100);

    run_txn(34);
    run_txn(35);

    sb.push_back(model(0));
    arm();
    cnt = 0;
    for (int i = 0; i < ARMT + 100; i++) begin
      @(posedge clk);
      cnt++;
      @(negedge clk);
      if (out_valid) break;
    end
    chk("arm_timeout_latency", cnt, ARMT);
    wait_idle(100);

    hold_ready = 1'b1;
    ready_val  = 1'b0;
    sb.push_back(model(4));
    arm();
    train(4);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    chk("done_reached", out_valid, 1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      start = 1'($urandom_range(0, 1));
      q_ser = ~q_ser;
      if (i == 10) chk("busy_in_done", busy, 0);
    end
    start = 1'b0;
    q_ser = 1'b0;
    @(negedge clk);
    ready_val = 1'b1;
    wait_idle(50);
    hold_ready = 1'b0;

    arm();
    train(2);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_zero("mid_train_reset");
    train(3);
    @(negedge clk);
    chk_zero("reset_held");
    rst = 1'b0;
    repeat (GAP + 4) @(negedge clk);
    chk_zero("no_result_after_reset");
    run_txn(5);

    @(negedge clk);
    q_ser = 1'b1;
    repeat (6) @(negedge clk);
    sb.push_back(model(2));
    arm();
    repeat (5) @(negedge clk);
    q_ser = 1'b0;
    repeat (3) @(negedge clk);
    train(2);
    wait_idle(300);

    for (int k = 0; k < 10; k++) begin
      run_txn(int'($urandom_range(1, 40)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
